// File: rtl/rom_burst_reader.sv
// Burst sequencer for a 1-cycle-latency synchronous ROM: issues consecutive reads and
// returns the words as a valid/ready stream through a 2-entry skid buffer.
//
// state | meaning
// IDLE  | waiting for start; empty bursts complete here
// RUN   | issuing ROM reads while words remain
// DRAIN | all reads issued, waiting for the last beat to be accepted
module rom_burst_reader #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] REM_ZERO = '0;

    state_t state;
    state_t state_nxt;

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic              inflight;
    logic              inflight_last;
    logic              done_q;

    logic [DATA_W-1:0] buf_data [2];
    logic [1:0]        buf_last;
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        buf_cnt;

    logic              issue;
    logic              pop;
    logic              push;
    logic              accept;
    logic              empty_start;
    logic              last_pop;
    logic [2:0]        occupancy;

    assign m_valid     = (buf_cnt != 2'd0);
    assign pop         = m_valid & m_ready;
    assign push        = inflight;
    assign last_pop    = pop & buf_last[rd_ptr];
    assign accept      = (state == S_IDLE) & start & (length != REM_ZERO);
    assign empty_start = (state == S_IDLE) & start & (length == REM_ZERO);

    // Slots committed after this edge: buffered + arriving - leaving. A read is only
    // issued if its word is guaranteed a slot, so the buffer can never overflow.
    assign occupancy = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (issue && (remaining == REM_ONE)) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_pop) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        issue = 1'b0;
        busy  = 1'b0;
        case (state)
            S_RUN: begin
                busy  = 1'b1;
                issue = (remaining != REM_ZERO) && (occupancy < 3'd2);
            end
            S_DRAIN: begin
                busy = 1'b1;
            end
            default: begin
                issue = 1'b0;
                busy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr          <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q        <= empty_start | ((state == S_DRAIN) & last_pop);
            inflight      <= issue;
            inflight_last <= issue & (remaining == REM_ONE);
            if (accept) begin
                addr      <= start_addr;
                remaining <= length;
            end else if (issue) begin
                addr      <= addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
        end
    end

    // rom_data is only looked at on edges where a read is actually in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_last    <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            buf_cnt     <= 2'd0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= rom_data;
                buf_last[wr_ptr] <= inflight_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   buf_cnt <= buf_cnt + 2'd1;
                2'b01:   buf_cnt <= buf_cnt - 2'd1;
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

    assign rom_en   = issue;
    assign rom_addr = addr;
    assign done     = done_q;
    assign m_data   = m_valid ? buf_data[rd_ptr] : '0;
    assign m_last   = m_valid & buf_last[rd_ptr];

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (({1'b0, buf_cnt} + {2'b00, inflight}) <= 3'd2));

    a_hold_stalled: assert property (@(posedge clk) disable iff (rst)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data) && $stable(m_last)));

endmodule
